task_mem_loader: RTL and testbench
==================================

// Module: task_mem_loader
// PURPOSE
//  Double-buffered loader for the Task Scheduler's task memory. It takes a word stream from the host
//  (valid/ready) into a shadow bank while the scheduler runs from the active bank. At a safe point
//  reported by the scheduler it swaps banks, then pulses a restart so scheduling begins at frame 0.
//  Sits between the host/env interface and the env_task_memory input of the scheduler.
// PARAMETERS
//  WORD_W      32  width of one host beat
//  FRAME_WORDS 8   beats per task-memory frame (frame width = FRAME_WORDS*WORD_W)
//  TM_DEPTH    16  frames per bank
//  RST_CYC     2   length of ts_restart pulse, cycles (>=1)
// PORTS
//  clk             in   1                        system clock
//  reset           in   1                        asynchronous, active-high
//  host_valid      in   1                        beat valid
//  host_ready      out  1                        loader accepts beat (beat taken when valid&ready)
//  host_data       in   WORD_W                   beat payload; word 0 = frame bits [WORD_W-1:0]
//  host_last       in   1                        last beat of program
//  sched_idle      in   1                        scheduler at safe swap point (frame num 0, all cores ready)
//  env_task_memory out  TM_DEPTH*FRAME_WORDS*WORD_W  active bank, frame i at [(i+1)*FW-1 : i*FW]
//  ts_restart      out  1                        held high RST_CYC cycles after swap; drives scheduler reset
//  load_busy       out  1                        high in FILL/WAIT_SWAP/SWAP/RESTART
//  err_overflow    out  1                        sticky: beats arrived after TM_DEPTH full frames
//  err_partial     out  1                        sticky: host_last not on a frame boundary
// BEHAVIOUR
//  - State: bank_sel, cnt[bank] (valid frames 0..TM_DEPTH), word_cnt, frame_cnt, FSM.
//  - Reset: FSM=IDLE, bank_sel=0, cnt[0]=cnt[1]=0, all errors 0, ts_restart=0.
//    Storage is not reset.
//  - Output masking: env_task_memory frame i = bank[bank_sel][i] if i<cnt[bank_sel], else all zero.
//    After reset the bus is therefore all zero.
//  - IDLE: host_ready=1. The first accepted beat is written to word 0 of frame 0; go to FILL
//    (or to WAIT_SWAP if that beat is last and FRAME_WORDS==1).
//  - FILL: host_ready=1. Each beat writes shadow[frame_cnt][word_cnt], then word_cnt++.
//    - At word_cnt==FRAME_WORDS-1: word_cnt wraps to 0 and frame_cnt++.
//    - frame_cnt==TM_DEPTH: beats are accepted and dropped; err_overflow set.
//  - host_last accepted in FILL:
//    - On a frame boundary (word_cnt==FRAME_WORDS-1) and no overflow in this load:
//      cnt[shadow]=frame_cnt+1 (capped at TM_DEPTH), go to WAIT_SWAP.
//    - Otherwise: set err_partial (boundary miss) and/or rely on err_overflow; discard the load
//      (cnt unchanged, active untouched); return to IDLE.
//  - WAIT_SWAP: host_ready=0; stay until sched_idle=1, then SWAP.
//  - SWAP (1 cycle): bank_sel toggles. env_task_memory changes on the same edge that enters
//    RESTART. ts_restart rises on that edge.
//  - RESTART: ts_restart=1 for exactly RST_CYC cycles, then IDLE (host_ready=1 next cycle).
//  - Errors clear only on reset. A new load starting while an error is set is legal.
//  - Shadow bank writes never alter the env_task_memory bus.
//  - Reset mid-load: everything returns to the reset state; the partially filled shadow is
//    invisible because cnt=0.
//  - sched_idle asserted outside WAIT_SWAP is ignored. sched_idle glitching for 1 cycle in
//    WAIT_SWAP is sufficient to swap.
//  - Latency: last beat accepted at cycle t with sched_idle=1 -> bank swap at t+2,
//    ts_restart high t+2..t+1+RST_CYC.
// TESTING
//  1. Reset, FRAME_WORDS=8: host_ready=1 after reset; env_task_memory==0; ts_restart=0.
//  2. Load 2 frames (16 beats 0x1..0x10, last on beat 16), sched_idle=1: frame0 word0=0x1,
//     frame1 word7=0x10, frames 2..15 zero; ts_restart high 2 cycles; bank_sel=1.
//  3. Same load with sched_idle=0 for 50 cycles: active bus unchanged, host_ready=0; swap
//     2 cycles after sched_idle rises.
//  4. host_last on beat 5: err_partial=1, FSM returns to IDLE, no swap, bus unchanged.
//  5. 17*8 beats, last on final beat: err_overflow=1, load discarded, no ts_restart.
//  6. Assert reset in FILL after 3 frames: bus zero, host_ready=1; a new 1-frame load then
//     commits correctly into bank 1.

Source files
------------

// File: rtl/task_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : task_mem_loader
//  Description : Double-buffered loader for the task scheduler's task memory.
//                Host beats fill the shadow bank while the active bank drives
//                env_task_memory. Once the scheduler reports a safe point the
//                banks swap and ts_restart is pulsed so scheduling restarts.
//  Revision    : 1.0  initial release
// ============================================================================
module task_mem_loader #(
  parameter int WORD_W      = 32,
  parameter int FRAME_WORDS = 8,
  parameter int TM_DEPTH    = 16,
  parameter int RST_CYC     = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   host_valid,
  output logic                                   host_ready,
  input  logic [WORD_W-1:0]                      host_data,
  input  logic                                   host_last,
  input  logic                                   sched_idle,
  output logic [TM_DEPTH*FRAME_WORDS*WORD_W-1:0] env_task_memory,
  output logic                                   ts_restart,
  output logic                                   load_busy,
  output logic                                   err_overflow,
  output logic                                   err_partial
);

  localparam int WC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int FA_W = (TM_DEPTH > 1) ? $clog2(TM_DEPTH) : 1;
  localparam int FC_W = $clog2(TM_DEPTH + 1);
  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_WAIT_SWAP = 3'd2,
    S_SWAP      = 3'd3,
    S_RESTART   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              bank_sel_q, bank_sel_d;
  logic [FC_W-1:0]   cnt_q [2];
  logic [FC_W-1:0]   cnt_d [2];
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              ovf_load_q, ovf_load_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_partial_q, err_partial_d;

  // Storage is deliberately left without reset; visibility is governed by cnt.
  logic [WORD_W-1:0] mem_q [2][TM_DEPTH][FRAME_WORDS];

  // Effective load position: a beat taken in IDLE always starts at frame 0 word 0.
  logic [WC_W-1:0]   wc;
  logic [FC_W-1:0]   fc;
  logic              ovf_prev;
  logic              at_boundary;
  logic              bank_full;
  logic              wr_en;
  logic [FA_W-1:0]   wr_frame;
  logic [WC_W-1:0]   wr_word;

  // Next-state, counter and error logic for the load/swap/restart sequence.
  always_comb begin
    state_d        = state_q;
    bank_sel_d     = bank_sel_q;
    cnt_d          = cnt_q;
    word_cnt_d     = word_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    ovf_load_d     = ovf_load_q;
    rst_cnt_d      = rst_cnt_q;
    err_overflow_d = err_overflow_q;
    err_partial_d  = err_partial_q;
    host_ready     = 1'b0;
    wr_en          = 1'b0;
    wc             = (state_q == S_IDLE) ? '0 : word_cnt_q;
    fc             = (state_q == S_IDLE) ? '0 : frame_cnt_q;
    ovf_prev       = (state_q == S_IDLE) ? 1'b0 : ovf_load_q;
    at_boundary    = (wc == WC_W'(FRAME_WORDS - 1));
    bank_full      = (fc == FC_W'(TM_DEPTH));
    wr_frame       = fc[FA_W-1:0];
    wr_word        = wc;

    case (state_q)
      S_IDLE, S_FILL: begin
        host_ready = 1'b1;
        if (host_valid) begin
          // Beats past the last frame are swallowed; the word counter keeps
          // running so a trailing host_last is still boundary-checked.
          if (bank_full) err_overflow_d = 1'b1;
          else           wr_en          = 1'b1;
          word_cnt_d  = at_boundary ? '0 : wc + 1'b1;
          frame_cnt_d = (at_boundary && !bank_full) ? fc + 1'b1 : fc;
          ovf_load_d  = ovf_prev | bank_full;
          state_d     = S_FILL;
          if (host_last) begin
            if (at_boundary && !ovf_prev && !bank_full) begin
              cnt_d[~bank_sel_q] = fc + 1'b1;
              state_d            = S_WAIT_SWAP;
            end else begin
              if (!at_boundary) err_partial_d = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_WAIT_SWAP: begin
        if (sched_idle) state_d = S_SWAP;
      end
      S_SWAP: begin
        bank_sel_d = ~bank_sel_q;
        rst_cnt_d  = '0;
        state_d    = S_RESTART;
      end
      S_RESTART: begin
        if (rst_cnt_q == RC_W'(RST_CYC - 1)) state_d = S_IDLE;
        else                                 rst_cnt_d = rst_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      bank_sel_q     <= 1'b0;
      cnt_q[0]       <= '0;
      cnt_q[1]       <= '0;
      word_cnt_q     <= '0;
      frame_cnt_q    <= '0;
      ovf_load_q     <= 1'b0;
      rst_cnt_q      <= '0;
      err_overflow_q <= 1'b0;
      err_partial_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      bank_sel_q     <= bank_sel_d;
      cnt_q[0]       <= cnt_d[0];
      cnt_q[1]       <= cnt_d[1];
      word_cnt_q     <= word_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      ovf_load_q     <= ovf_load_d;
      rst_cnt_q      <= rst_cnt_d;
      err_overflow_q <= err_overflow_d;
      err_partial_q  <= err_partial_d;
    end
  end

  // Shadow-bank write port; only the bank not selected for output is written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[~bank_sel_q][wr_frame][wr_word] <= host_data;
  end

  // Active bank onto the bus, frames beyond the committed count forced to zero.
  for (genvar i = 0; i < TM_DEPTH; i++) begin : g_frame
    logic frame_vis;
    assign frame_vis = (FC_W'(i) < cnt_q[bank_sel_q]);
    for (genvar w = 0; w < FRAME_WORDS; w++) begin : g_word
      assign env_task_memory[(i*FRAME_WORDS + w)*WORD_W +: WORD_W] =
        frame_vis ? mem_q[bank_sel_q][i][w] : '0;
    end
  end

  assign ts_restart   = (state_q == S_RESTART);
  assign load_busy    = (state_q != S_IDLE);
  assign err_overflow = err_overflow_q;
  assign err_partial  = err_partial_q;

endmodule
`default_nettype wire

// File: tb/tb_task_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_task_mem_loader
//  Description : Self-checking bench for task_mem_loader (default parameters).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_task_mem_loader;

  localparam int WORD_W      = 32;
  localparam int FRAME_WORDS = 8;
  localparam int TM_DEPTH    = 16;
  localparam int RST_CYC     = 2;
  localparam int BUS_W       = TM_DEPTH*FRAME_WORDS*WORD_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              host_valid = 1'b0;
  logic              host_ready;
  logic [WORD_W-1:0] host_data = '0;
  logic              host_last = 1'b0;
  logic              sched_idle = 1'b0;
  logic [BUS_W-1:0]  env_task_memory;
  logic              ts_restart;
  logic              load_busy;
  logic              err_overflow;
  logic              err_partial;

  task_mem_loader #(
    .WORD_W(WORD_W), .FRAME_WORDS(FRAME_WORDS), .TM_DEPTH(TM_DEPTH), .RST_CYC(RST_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
    .host_last(host_last), .sched_idle(sched_idle),
    .env_task_memory(env_task_memory), .ts_restart(ts_restart),
    .load_busy(load_busy), .err_overflow(err_overflow), .err_partial(err_partial)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model of the active bank: act_nf frames of consecutive words starting at act_base.
  int          act_nf   = 0;
  logic [31:0] act_base = '0;

  typedef struct {
    int          n;
    logic [31:0] base;
    bit          commit;
    bit          e_part;
    bit          e_ovf;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int f, input int w);
    return (f < act_nf) ? act_base + 32'(f*FRAME_WORDS + w) : 32'h0;
  endfunction

  function automatic int first_bad();
    for (int f = 0; f < TM_DEPTH; f++)
      for (int w = 0; w < FRAME_WORDS; w++)
        if (env_task_memory[(f*FRAME_WORDS + w)*WORD_W +: WORD_W] !== exp_word(f, w))
          return f*FRAME_WORDS + w;
    return -1;
  endfunction

  task automatic chk_bus(input string nm);
    int b;
    b = first_bad();
    n_cmp++;
    if (b >= 0) begin
      n_fail++;
      $display("FAIL %s: bus word %0d got %0h expected %0h", nm, b,
               env_task_memory[b*WORD_W +: WORD_W], exp_word(b / FRAME_WORDS, b % FRAME_WORDS));
    end
  endtask

  task automatic send_load(input int n, input logic [31:0] base, input bit with_last);
    for (int k = 0; k < n; k++) begin
      int g;
      @(negedge clk);
      host_valid = 1'b1;
      host_data  = base + 32'(k);
      host_last  = with_last && (k == n - 1);
      g = 0;
      while (!host_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (!host_ready) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_load: host_ready stuck low at beat %0d", k);
      end
    end
    @(negedge clk);
    host_valid = 1'b0;
    host_last  = 1'b0;
  endtask

  task automatic wait_done(output int ts_seen);
    int cyc;
    cyc     = 0;
    ts_seen = 0;
    while (load_busy && cyc < 100) begin
      if (ts_restart) ts_seen++;
      @(negedge clk);
      cyc++;
    end
    if (load_busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_done: load_busy still %0b after %0d cycles", load_busy, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ts_seen;
    int bad_rdy;
    int bad_bus;

    tbl[0] = '{8,   32'h0000_0100, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{5,   32'h0000_0200, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{128, 32'h0000_1000, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{136, 32'h0000_2000, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{24,  32'h0000_3000, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1,   32'h0000_4000, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_host_ready", 64'(host_ready), 64'd1);
    chk("rst_ts_restart", 64'(ts_restart), 64'd0);
    chk("rst_load_busy", 64'(load_busy), 64'd0);
    chk("rst_err_ovf", 64'(err_overflow), 64'd0);
    chk("rst_err_part", 64'(err_partial), 64'd0);
    chk_bus("rst_bus");

    // Two-frame load with sched_idle already high: swap latency and restart width
    sched_idle = 1'b1;
    send_load(16, 32'h1, 1'b1);
    chk("lat_ts_c0", 64'(ts_restart), 64'd0);
    chk("lat_ready_c0", 64'(host_ready), 64'd0);
    @(negedge clk);
    chk("lat_ts_c1", 64'(ts_restart), 64'd0);
    chk_bus("lat_bus_c1_old");
    @(negedge clk);
    act_nf = 2; act_base = 32'h1;
    chk("lat_ts_c2", 64'(ts_restart), 64'd1);
    chk_bus("lat_bus_c2_new");
    chk("lat_f0w0", 64'(env_task_memory[31:0]), 64'h1);
    chk("lat_f1w7", 64'(env_task_memory[15*WORD_W +: WORD_W]), 64'h10);
    chk("lat_f2w0", 64'(env_task_memory[16*WORD_W +: WORD_W]), 64'h0);
    @(negedge clk);
    chk("lat_ts_c3", 64'(ts_restart), 64'd1);
    @(negedge clk);
    chk("lat_ts_c4", 64'(ts_restart), 64'd0);
    chk("lat_ready_c4", 64'(host_ready), 64'd1);
    chk("lat_busy_c4", 64'(load_busy), 64'd0);

    // Scheduler not idle for 50 cycles, then a one-cycle sched_idle glitch
    sched_idle = 1'b0;
    send_load(16, 32'h500, 1'b1);
    bad_rdy = 0;
    bad_bus = 0;
    for (int c = 0; c < 50; c++) begin
      if (host_ready !== 1'b0) bad_rdy++;
      if (first_bad() >= 0 || ts_restart !== 1'b0) bad_bus++;
      @(negedge clk);
    end
    chk("wait_ready_low_cycles", 64'(bad_rdy), 64'd0);
    chk("wait_bus_held_cycles", 64'(bad_bus), 64'd0);
    chk("wait_busy", 64'(load_busy), 64'd1);
    sched_idle = 1'b1;
    @(negedge clk);
    sched_idle = 1'b0;
    chk("glitch_ts_c1", 64'(ts_restart), 64'd0);
    chk_bus("glitch_bus_c1_old");
    @(negedge clk);
    act_nf = 2; act_base = 32'h500;
    chk("glitch_ts_c2", 64'(ts_restart), 64'd1);
    chk_bus("glitch_bus_c2_new");
    wait_done(ts_seen);
    chk("glitch_ts_len", 64'(ts_seen), 64'(RST_CYC));

    // Table of loads: commits, partial, full bank, overflow, load with errors set
    sched_idle = 1'b1;
    for (int v = 0; v < 6; v++) begin
      send_load(tbl[v].n, tbl[v].base, 1'b1);
      wait_done(ts_seen);
      if (tbl[v].commit) begin
        act_nf   = tbl[v].n / FRAME_WORDS;
        act_base = tbl[v].base;
      end
      chk($sformatf("tbl%0d_ts_len", v), 64'(ts_seen), tbl[v].commit ? 64'(RST_CYC) : 64'd0);
      chk_bus($sformatf("tbl%0d_bus", v));
      chk($sformatf("tbl%0d_err_part", v), 64'(err_partial), 64'(tbl[v].e_part));
      chk($sformatf("tbl%0d_err_ovf", v), 64'(err_overflow), 64'(tbl[v].e_ovf));
      chk($sformatf("tbl%0d_ready", v), 64'(host_ready), 64'd1);
    end

    // Reset in FILL after three frames, then a fresh one-frame load
    send_load(24, 32'h6000, 1'b0);
    chk("mid_busy_before_rst", 64'(load_busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    act_nf = 0;
    chk_bus("mid_rst_bus");
    chk("mid_rst_ready", 64'(host_ready), 64'd1);
    chk("mid_rst_busy", 64'(load_busy), 64'd0);
    chk("mid_rst_err_ovf", 64'(err_overflow), 64'd0);
    chk("mid_rst_err_part", 64'(err_partial), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    send_load(8, 32'h700, 1'b1);
    wait_done(ts_seen);
    act_nf = 1; act_base = 32'h700;
    chk("post_rst_ts_len", 64'(ts_seen), 64'(RST_CYC));
    chk_bus("post_rst_bus");
    chk("post_rst_err_part", 64'(err_partial), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
